// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter funnelling NREQ requesters onto one APB master port.
// Every output is a flop; a stalled ACCESS is forced to finish after TIMEOUT waits.
module apb_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 300
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_write,
  input  logic [32*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0]  req_wdata,
  output logic [NREQ-1:0]     req_done,
  output logic [31:0]         req_rdata,
  output logic                req_err,
  output logic [31:0]         PADDR,
  output logic                PWRITE,
  output logic                PSEL,
  output logic                PENABLE,
  output logic [31:0]         PWDATA,
  input  logic [31:0]         PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [9:0]      wcnt_q, wcnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [31:0]     paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [31:0]     pwdata_q, pwdata_d;

  // Rotate so the requester after last_q sits at bit 0, then take the lowest set bit.
  int              shamt;
  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] lsb;
  logic [GW-1:0]   off;
  logic [GW-1:0]   win;

  always_comb begin
    shamt = (int'(last_q) + 1) % NREQ;
    rot   = NREQ'({req_valid, req_valid} >> shamt);
    lsb   = rot & (~rot + NREQ'(1));
    off   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (lsb == (NREQ'(1) << j)) off = GW'(j);
    end
    win = GW'((shamt + int'(off)) % NREQ);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wcnt_d    = wcnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwdata_d  = pwdata_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          paddr_d   = 32'(req_addr >> (32 * int'(win)));
          pwdata_d  = 32'(req_wdata >> (32 * int'(win)));
          pwrite_d  = |(req_write & (NREQ'(1) << win));
          psel_d    = 1'b1;
          penable_d = 1'b0;
          grant_d   = win;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wcnt_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY || (wcnt_q == 10'(TIMEOUT))) begin
          done_d    = NREQ'(1) << grant_q;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          last_d    = grant_q;
          state_d   = IDLE;
          if (PREADY) begin
            err_d = PSLVERR;
            if (!pwrite_q) rdata_d = PRDATA;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end else begin
          wcnt_d = wcnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(NREQ - 1);
      wcnt_q    <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wcnt_q    <= wcnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign req_done  = done_q;
  assign req_rdata = rdata_q;
  assign req_err   = err_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_apb_req_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 300;

  logic                PCLK;
  logic                PRESETn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_write;
  logic [32*NREQ-1:0]  req_addr;
  logic [32*NREQ-1:0]  req_wdata;
  logic [NREQ-1:0]     req_done;
  logic [31:0]         req_rdata;
  logic                req_err;
  logic [31:0]         PADDR;
  logic                PWRITE;
  logic                PSEL;
  logic                PENABLE;
  logic [31:0]         PWDATA;
  logic [31:0]         PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a transfer is "busy" for age 1 (setup) and age>=2 (access).
  logic            m_busy;
  int              m_age;
  int              m_g;
  int              m_last;
  logic [31:0]     m_addr, m_wd, m_rd;
  logic            m_wr, m_err;
  logic [NREQ-1:0] m_done;

  function automatic int pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_busy <= 1'b0; m_age <= 0; m_g <= 0; m_last <= NREQ - 1;
      m_addr <= '0; m_wd <= '0; m_rd <= '0;
      m_wr <= 1'b0; m_err <= 1'b0; m_done <= '0;
    end else begin
      m_done <= '0;
      if (!m_busy) begin
        if (|req_valid) begin
          m_busy <= 1'b1;
          m_age  <= 1;
          m_g    <= pick(m_last, req_valid);
          m_addr <= req_addr[32*pick(m_last, req_valid) +: 32];
          m_wd   <= req_wdata[32*pick(m_last, req_valid) +: 32];
          m_wr   <= req_write[pick(m_last, req_valid)];
        end
      end else if (m_age == 1) begin
        m_age <= 2;
      end else if (PREADY || (m_age - 2 == TIMEOUT)) begin
        m_busy <= 1'b0;
        m_done <= NREQ'(1) << m_g;
        m_last <= m_g;
        m_wr   <= 1'b0;
        m_err  <= PREADY ? PSLVERR : 1'b1;
        if (!PREADY) m_rd <= '0;
        else if (!m_wr) m_rd <= PRDATA;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  // Compare + monitor bookkeeping on the falling edge.
  int          cyc = 0;
  int          psel_n = 0;
  int          pen_n = 0;
  int          grant_cnt = 0;
  int          done_cnt = 0;
  int          gstamp = 0;
  int          gq[$];
  int          dq[$];
  logic [31:0] last_rd;
  logic        last_err;

  initial begin
    #2;
    forever begin
      @(negedge PCLK);
      chk("PSEL", 32'(PSEL), 32'(m_busy));
      chk("PENABLE", 32'(PENABLE), 32'(m_busy && m_age >= 2));
      chk("PADDR", PADDR, m_addr);
      chk("PWDATA", PWDATA, m_wd);
      chk("PWRITE", 32'(PWRITE), 32'(m_wr));
      chk("req_done", 32'(req_done), 32'(m_done));
      chk("done_onehot", 32'($countones(req_done) <= 1), 32'(1));
      if (m_done != '0) begin
        chk("req_rdata", req_rdata, m_rd);
        chk("req_err", 32'(req_err), 32'(m_err));
      end
      if (req_done != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_done[i]) gq.push_back(i);
        dq.push_back(cyc);
        last_rd  = req_rdata;
        last_err = req_err;
        done_cnt++;
      end
      if (PSEL && !PENABLE) begin
        grant_cnt++;
        gstamp = cyc;
      end
      if (PSEL) psel_n++;
      if (PENABLE) pen_n++;
      cyc++;
    end
  end

  // APB slave: inserts wait_n wait states; PSLVERR either tied or high only while waiting.
  int   wait_n = 0;
  int   acc_n = 0;
  logic slv_tie = 1'b0;
  logic slv_wait = 1'b0;

  initial begin
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PENABLE) begin
        PREADY = (acc_n >= wait_n);
        acc_n++;
      end else begin
        acc_n = 0;
        PREADY = 1'b0;
      end
      PSLVERR = slv_wait ? (PENABLE && !PREADY) : slv_tie;
    end
  end

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i] = wr;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
  endtask

  // Raise v until n grants are seen, scramble request fields, then wait for n completions.
  task automatic xfer(input logic [NREQ-1:0] v, input int n, input int bound);
    int g0, d0, k;
    @(posedge PCLK); #1;
    psel_n = 0;
    pen_n  = 0;
    g0 = grant_cnt;
    d0 = done_cnt;
    req_valid = v;
    k = 0;
    while (grant_cnt < g0 + n && k < bound) begin
      @(posedge PCLK); k++;
    end
    #1;
    req_valid = '0;
    req_addr  = {NREQ{32'hBAD0_0BAD}};
    req_wdata = {NREQ{32'h5A5A_A5A5}};
    req_write = ~req_write;
    chk("grant_wait", 32'(grant_cnt >= g0 + n), 32'(1));
    k = 0;
    while (done_cnt < d0 + n && k < bound) begin
      @(posedge PCLK); k++;
    end
    chk("done_wait", 32'(done_cnt >= d0 + n), 32'(1));
  endtask

  initial begin
    int g0, d0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PRDATA    = '0;
    PRESETn   = 1'b1;
    #1 PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_PSEL", 32'(PSEL), 0);
    chk("rst_PENABLE", 32'(PENABLE), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_err", 32'(req_err), 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_PADDR", PADDR, 0);
    chk("rst_PWDATA", PWDATA, 0);
    chk("rst_PWRITE", 32'(PWRITE), 0);
    PRESETn = 1'b1;

    // Single write from requester 0, zero wait states.
    set_req(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    wait_n = 0;
    xfer(2'b01, 1, 20);
    chk("t1_psel_cycles", 32'(psel_n), 2);
    chk("t1_pen_cycles", 32'(pen_n), 1);
    chk("t1_grant", 32'(gq[$]), 0);
    chk("t1_err", 32'(last_err), 0);
    chk("t1_latency", 32'(dq[$] - gstamp), 2);

    // Read from requester 1 with five wait states.
    set_req(1, 1'b0, 32'h0000_0020, 32'h0);
    PRDATA = 32'h1234_5678;
    wait_n = 5;
    xfer(2'b10, 1, 40);
    chk("t2_access_cycles", 32'(pen_n), 6);
    chk("t2_grant", 32'(gq[$]), 1);
    chk("t2_rdata", last_rd, 32'h1234_5678);
    chk("t2_err", 32'(last_err), 0);

    // Both requesters continuously valid: strict alternation, 3-cycle period.
    set_req(0, 1'b1, 32'h0000_0100, 32'h0000_0011);
    set_req(1, 1'b0, 32'h0000_0200, 32'h0);
    PRDATA = 32'hCAFE_0001;
    wait_n = 0;
    d0 = gq.size();
    xfer(2'b11, 6, 100);
    for (int i = 0; i < 6; i++) chk("t3_order", 32'(gq[d0 + i]), 32'(i % 2));
    for (int i = 1; i < 6; i++) chk("t3_spacing", 32'(dq[d0 + i] - dq[d0 + i - 1]), 3);

    // PREADY never rises: forced termination.
    set_req(0, 1'b0, 32'h0000_0300, 32'h0);
    PRDATA = 32'hAAAA_5555;
    wait_n = 100000;
    xfer(2'b01, 1, 400);
    chk("t4_access_cycles", 32'(pen_n), 301);
    chk("t4_err", 32'(last_err), 1);
    chk("t4_rdata", last_rd, 0);
    @(negedge PCLK);
    chk("t4_psel_low", 32'(PSEL), 0);

    // Slave error on a write, then a clean read with PSLVERR high only while waiting.
    set_req(1, 1'b1, 32'h0000_0400, 32'h0000_0055);
    slv_tie = 1'b1;
    wait_n = 0;
    xfer(2'b10, 1, 20);
    chk("t5_err", 32'(last_err), 1);
    slv_tie = 1'b0;
    slv_wait = 1'b1;
    set_req(0, 1'b0, 32'h0000_0500, 32'h0);
    PRDATA = 32'h0BAD_F00D;
    wait_n = 3;
    xfer(2'b01, 1, 30);
    chk("t5b_err", 32'(last_err), 0);
    chk("t5b_rdata", last_rd, 32'h0BAD_F00D);
    slv_wait = 1'b0;

    // Reset in the middle of an ACCESS phase.
    set_req(0, 1'b0, 32'h0000_0600, 32'h0);
    set_req(1, 1'b0, 32'h0000_0700, 32'h0);
    wait_n = 100000;
    @(posedge PCLK); #1;
    req_valid = 2'b10;
    d0 = done_cnt;
    repeat (3) @(posedge PCLK);
    #1;
    chk("t6_in_access", 32'(PENABLE), 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("t6_rst_psel", 32'(PSEL), 0);
    chk("t6_rst_pen", 32'(PENABLE), 0);
    req_valid = 2'b11;
    wait_n = 0;
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1'b1;
    chk("t6_no_done", 32'(done_cnt), 32'(d0));
    g0 = gq.size();
    xfer(2'b11, 1, 20);
    chk("t6_first_grant", 32'(gq[g0]), 0);
    chk("t6_done_count", 32'(done_cnt), 32'(d0 + 1));

    repeat (3) @(posedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameters SHALL be:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 300, maximum PREADY wait states before forced termination.
REQ-002 Ports SHALL be:
- PCLK  in  1  sole clock; all state updates on rising edge.
- PRESETn  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  per-requester transfer request, level.
- req_write  in  NREQ  per-requester direction; 1 = write.
- req_addr  in  32*NREQ  per-requester address; requester i occupies bits [32i+31:32i].
- req_wdata  in  32*NREQ  per-requester write data, same packing.
- req_done  out  NREQ  one-cycle completion pulse to the granted requester.
- req_rdata  out  32  read data, valid in the req_done cycle.
- req_err  out  1  error flag, valid in the req_done cycle.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.
REQ-003 All outputs SHALL be driven directly from flops.

Function
REQ-004 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-005 IDLE: if any req_valid is high, the winner is chosen round-robin, searching from (last_grant+1) mod NREQ upward with wrap. At that edge the block SHALL latch the winner's addr/write/wdata into PADDR/PWRITE/PWDATA, set PSEL=1 and PENABLE=0, record the winner index, and go to SETUP.
REQ-006 SETUP SHALL last exactly one cycle, then set PENABLE=1 and go to ACCESS.
REQ-007 ACCESS, PREADY=1 sampled: complete the transfer.
- req_done[grant] pulses for one cycle.
- req_rdata=PRDATA if the transfer is a read; otherwise req_rdata holds its previous value.
- req_err=PSLVERR.
- PSEL=0, PENABLE=0, PWRITE=0.
- last_grant=grant; next state IDLE.
REQ-008 ACCESS, PREADY=0: a 10-bit wait counter (cleared on entering ACCESS) SHALL increment each cycle. When the counter equals TIMEOUT with PREADY still 0, the block SHALL complete as in REQ-007 but with req_err=1 and req_rdata=0.
REQ-009 Minimum transfer with PREADY=1 in the first ACCESS cycle SHALL be 3 cycles: grant edge, SETUP, ACCESS. IDLE SHALL be occupied for at least one cycle between transfers.
REQ-010 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP until completion, regardless of changes on req_* inputs.
REQ-011 req_valid deasserting after grant SHALL NOT abort the transfer; req_done is still issued.
REQ-012 A requester holding req_valid high through its own req_done SHALL be treated as a new request in the next IDLE cycle, subject to round-robin order.
REQ-013 With all NREQ requesters continuously valid, grants SHALL rotate 0,1,...,NREQ-1,0,... with no requester skipped.
REQ-014 At most one req_done bit SHALL be high in any cycle.
REQ-015 PSLVERR SHALL be ignored outside the completing ACCESS cycle.

Reset
REQ-016 While PRESETn=0, all outputs SHALL be 0, state IDLE, wait counter 0, last_grant=NREQ-1 so requester 0 wins first.
REQ-017 PRESETn asserting mid-transfer SHALL immediately drop PSEL/PENABLE. The aborted requester SHALL receive no req_done.
REQ-018 The first grant after PRESETn rises SHALL occur no earlier than the first PCLK rising edge with PRESETn=1.

Verification
REQ-019 Single write, req 0 addr 0x1000 data 0xDEADBEEF, PREADY tied 1 -> PSEL high 2 cycles, PENABLE high 1 cycle, req_done[0] pulse, req_err=0, 3 cycles total.
REQ-020 Read from req 1 addr 0x20, PREADY low 5 cycles, PRDATA=0x12345678 -> ACCESS lasts 6 cycles, req_rdata=0x12345678 in the req_done[1] cycle.
REQ-021 Both requesters valid continuously for 6 transfers -> grant order 0,1,0,1,0,1; each transfer separated by one IDLE cycle.
REQ-022 PREADY held 0 -> completion after TIMEOUT=300 wait states, req_err=1, req_rdata=0, PSEL returns to 0.
REQ-023 PREADY=1 with PSLVERR=1 on a write -> req_err=1 in the req_done cycle; the next transfer reports req_err=0.
REQ-024 PRESETn pulsed low during ACCESS -> PSEL/PENABLE=0 asynchronously, no req_done; after release, requester 0 is granted first.
